// File: rtl/cq_viola_pkg.sv
// Shared state encoding, bus addresses and expected system-ID words for the
// sysid checker slice.
package cq_viola_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ID_REQ  = 3'd1,
    ST_ID_WAIT = 3'd2,
    ST_TS_REQ  = 3'd3,
    ST_TS_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic        SYSID_ADDR_ID = 1'b0;
  localparam logic        SYSID_ADDR_TS = 1'b1;
  localparam logic [31:0] SYSID_EXP_ID  = 32'hA013_0917;
  localparam logic [31:0] SYSID_EXP_TS  = 32'h5267_3D51;

  function automatic logic is_req(input state_t s);
    return (s == ST_ID_REQ) || (s == ST_TS_REQ);
  endfunction

  function automatic logic is_wait(input state_t s);
    return (s == ST_ID_WAIT) || (s == ST_TS_WAIT);
  endfunction

endpackage

// File: rtl/cq_viola_timeout_ctr.sv
// Per-read watchdog: counts cycles while enabled and flags the last allowed
// cycle of a read window.
module cq_viola_timeout_ctr #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned   CW   = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_r;

  // Cycle counter; clear takes priority so a new read window starts at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (enable) begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && (count_r == LAST);

endmodule

// File: rtl/cq_viola_sysid_checker.sv
// Reads the system-ID slave's ID and timestamp words after reset or on start
// and reports whether both match their expected values.
module cq_viola_sysid_checker
  import cq_viola_pkg::*;
#(
  parameter logic [31:0] EXP_ID     = SYSID_EXP_ID,
  parameter logic [31:0] EXP_TS     = SYSID_EXP_TS,
  parameter int unsigned TIMEOUT    = 256,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_t state_r;
  state_t state_s;
  logic   auto_pend_r;
  logic   expired_s;
  logic   ctr_clear_s;
  logic   ctr_enable_s;
  logic   launch_s;
  logic   cap_id_s;
  logic   cap_ts_s;
  logic   timeout_s;

  assign ctr_enable_s = is_req(state_r) || is_wait(state_r);
  assign ctr_clear_s  = is_req(state_s) && (state_s != state_r);

  cq_viola_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (ctr_clear_s),
    .enable  (ctr_enable_s),
    .expired (expired_s)
  );

  // State register; the auto-start request lives only for the first cycle out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      auto_pend_r <= AUTO_START;
    end else begin
      state_r     <= state_s;
      auto_pend_r <= 1'b0;
    end
  end

  // Next state and one-cycle action strobes; readdatavalid beats an expiring window.
  always_comb begin
    state_s   = state_r;
    launch_s  = 1'b0;
    cap_id_s  = 1'b0;
    cap_ts_s  = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start || auto_pend_r) begin
          state_s  = ST_ID_REQ;
          launch_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ID_REQ: begin
        if (expired_s) begin
          state_s   = ST_DONE;
          timeout_s = 1'b1;
        end else if (!avm_waitrequest) begin
          state_s = ST_ID_WAIT;
        end else begin
          state_s = ST_ID_REQ;
        end
      end
      ST_ID_WAIT: begin
        if (avm_readdatavalid) begin
          state_s  = ST_TS_REQ;
          cap_id_s = 1'b1;
        end else if (expired_s) begin
          state_s   = ST_DONE;
          timeout_s = 1'b1;
        end else begin
          state_s = ST_ID_WAIT;
        end
      end
      ST_TS_REQ: begin
        if (expired_s) begin
          state_s   = ST_DONE;
          timeout_s = 1'b1;
        end else if (!avm_waitrequest) begin
          state_s = ST_TS_WAIT;
        end else begin
          state_s = ST_TS_REQ;
        end
      end
      ST_TS_WAIT: begin
        if (avm_readdatavalid) begin
          state_s  = ST_DONE;
          cap_ts_s = 1'b1;
        end else if (expired_s) begin
          state_s   = ST_DONE;
          timeout_s = 1'b1;
        end else begin
          state_s = ST_TS_WAIT;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_s  = ST_ID_REQ;
          launch_s = 1'b1;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Bus and status outputs are registered from the next state; captures update with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= 32'h0000_0000;
      ts_value    <= 32'h0000_0000;
    end else begin
      avm_read    <= is_req(state_s);
      avm_address <= ((state_s == ST_TS_REQ) || (state_s == ST_TS_WAIT)) ? SYSID_ADDR_TS
                                                                         : SYSID_ADDR_ID;
      busy        <= is_req(state_s) || is_wait(state_s);
      done        <= (state_s == ST_DONE);
      if (launch_s) begin
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
        timeout_err <= 1'b0;
        id_value    <= 32'h0000_0000;
        ts_value    <= 32'h0000_0000;
      end else begin
        if (cap_id_s) begin
          id_value <= avm_readdata;
          id_ok    <= (avm_readdata == EXP_ID);
        end
        if (cap_ts_s) begin
          ts_value <= avm_readdata;
          ts_ok    <= (avm_readdata == EXP_TS);
        end
        if (timeout_s) begin
          timeout_err <= 1'b1;
        end
      end
    end
  end

endmodule
